nibble_add_seq: RTL and testbench



---
 rtl/nibble_add_seq_pkg.sv | 28 ++
 rtl/nibble_add_seq_csa_nibble.sv | 38 +++
 rtl/nibble_add_seq.sv | 109 ++++++++++
 tb/tb_nibble_add_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
//   state_e  : FSM state encoding (IDLE / RUN / DONE)
//   NIBBLE_W : width of the time-multiplexed adder slice
//   clog2()  : index-counter width for a given nibble count, never below 1 bit
package nibble_add_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam int unsigned NIBBLE_W = 4;

  // Ceiling log2, floored at 1 so a single-nibble build still has a legal index register.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_add_seq_csa_nibble.sv
// Combinational 4-bit carry-select adder slice.
//   a, b : nibble operands
//   cin  : carry in, selects between the two precomputed ripple chains
//   s    : nibble sum
//   cout : carry out of bit 3
module csa_nibble
  import nibble_add_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] s0, s1;
  logic                c0, c1;

  // Both chains are evaluated in parallel; cin only drives the final mux.
  always_comb begin
    s0 = '0;
    s1 = '0;
    c0 = 1'b0;
    c1 = 1'b1;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      s0[i] = a[i] ^ b[i] ^ c0;
      c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
      s1[i] = a[i] ^ b[i] ^ c1;
      c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
    end
  end

  always_comb begin
    s    = cin ? s1 : s0;
    cout = cin ? c1 : c0;
  end

endmodule

// File: rtl/nibble_add_seq.sv
// Sequential W-bit adder/subtractor, W = 4*NIBBLES, reusing one carry-select nibble slice
// least-significant nibble first with the inter-nibble carry held in a register.
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   start, sub, a, b: request and operands, sampled only in IDLE or DONE
//   busy            : high while nibbles are being computed
//   done            : one-cycle pulse, sum/cout/ovf valid
//   sum, cout, ovf  : result, carry out of bit W-1 (1 = no borrow for sub), signed overflow
module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         sub,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout,
  output logic                         ovf
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned IW = clog2(NIBBLES);
  localparam logic [IW-1:0] LastIdx = IW'(NIBBLES - 1);

  state_e              state;
  logic [IW-1:0]       idx;
  logic                carry;
  logic [W-1:0]        op_a, op_b;
  logic [NIBBLE_W-1:0] sl_a, sl_b, sl_s;
  logic                sl_cout;

  // Select the current nibble of each operand copy.
  always_comb begin
    sl_a = op_a[NIBBLE_W-1:0];
    sl_b = op_b[NIBBLE_W-1:0];
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        sl_a = op_a[i*NIBBLE_W +: NIBBLE_W];
        sl_b = op_b[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  csa_nibble u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction as a + ~b + 1: invert b here, the +1 enters as the first carry.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) sum[i*NIBBLE_W +: NIBBLE_W] <= sl_s;
          end
          carry <= sl_cout;
          idx   <= idx + IW'(1);
          if (idx == LastIdx) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= sl_cout;
            // Overflow uses the possibly-inverted operand, so one rule covers add and sub.
            ovf   <= (op_a[W-1] == op_b[W-1]) & (sl_s[NIBBLE_W-1] != op_a[W-1]);
            state <= StDone;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: a 4-nibble instance and a 1-nibble instance,
// directed and random operations checked against an arithmetic reference model.
module tb_nibble_add_seq;

  localparam int N4 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start1 = 1'b0, sub1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, cout1, ovf1;
  logic [3:0]  sum1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  nibble_add_seq #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_add_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // Reference: plain modular arithmetic on unsigned integers of width w.
  function automatic void model(input int unsigned x, input int unsigned y, input bit s,
                                input int w, output int unsigned r, output bit c,
                                output bit o);
    int unsigned m, t;
    bit sx, sy, sr;
    m = 32'd1 << w;
    t = s ? (x + m - y) : (x + y);
    c = (t >= m);
    r = t % m;
    sx = ((x >> (w - 1)) & 1) != 0;
    sy = ((y >> (w - 1)) & 1) != 0;
    sr = ((r >> (w - 1)) & 1) != 0;
    o = s ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
  endfunction

  // Runs one op on dut4; entered and left #1 after a rising edge, left in the done cycle.
  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb, input logic xs,
                       output int lat, output int bcyc, output logic [15:0] rs,
                       output logic rc, output logic ro);
    a = xa; b = xb; sub = xs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    lat = 1; bcyc = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
  endtask

  task automatic do_op1(input logic [3:0] xa, input logic [3:0] xb, input logic xs,
                        output int lat, output logic [3:0] rs, output logic rc,
                        output logic ro);
    a1 = xa; b1 = xb; sub1 = xs; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
    lat = 1;
    while (!done1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum1; rc = cout1; ro = ovf1;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if ({busy, done, sum, cout, ovf} !== 19'd0) begin
      $display("FAIL reset_outputs: got %h expected 0", {busy, done, sum, cout, ovf});
    end else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, busy1, done1} !== 4'd0) begin
      $display("FAIL idle_after_reset: got %b expected 0000", {busy, done, busy1, done1});
    end else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] vb [5] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [5] = '{16'h2233, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat, bcyc;
    logic [15:0] rs;
    logic rc, ro;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vs[i], lat, bcyc, rs, rc, ro);
      total_cnt++;
      if (lat !== N4 + 1 || bcyc !== N4) begin
        $display("FAIL directed%0d_timing: got lat=%0d busy=%0d expected lat=%0d busy=%0d",
                 i, lat, bcyc, N4 + 1, N4);
      end else pass_cnt++;
      total_cnt++;
      if ({rs, rc, ro} !== {es[i], ec[i], eo[i]}) begin
        $display("FAIL directed%0d_result: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                 i, rs, rc, ro, es[i], ec[i], eo[i]);
      end else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (done !== 1'b0 || sum !== es[i]) begin
        $display("FAIL directed%0d_hold: got done=%b sum=%h expected done=0 sum=%h",
                 i, done, sum, es[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int lat, bcyc;
    logic [15:0] rs, xa, xb;
    logic rc, ro, xs;
    int unsigned er;
    bit ec, eo;
    for (int i = 0; i < 30; i++) begin
      xa = 16'($urandom); xb = 16'($urandom); xs = 1'($urandom);
      model(xa, xb, xs, 16, er, ec, eo);
      do_op(xa, xb, xs, lat, bcyc, rs, rc, ro);
      total_cnt++;
      if (lat !== N4 + 1 || {rs, rc, ro} !== {er[15:0], ec, eo}) begin
        $display("FAIL random%0d: %h %s %h got sum=%h c=%b o=%b lat=%0d expected %h %b %b",
                 i, xa, xs ? "-" : "+", xb, rs, rc, ro, lat, er[15:0], ec, eo);
      end else pass_cnt++;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // start held high: acceptance at cycle 0 and in every done cycle, i.e. every N4+1 cycles.
  task automatic test_back_to_back();
    logic [15:0] va [16];
    logic [15:0] vb [16];
    logic        vs [16];
    int unsigned er;
    bit ec, eo, exp_done, exp_busy;
    int p;
    for (int k = 0; k < 16; k++) begin
      exp_done = (k > 0) && (k % (N4 + 1) == 0);
      exp_busy = (k % (N4 + 1)) != 0;
      total_cnt++;
      if (done !== exp_done || busy !== exp_busy) begin
        $display("FAIL b2b_cycle%0d: got done=%b busy=%b expected done=%b busy=%b",
                 k, done, busy, exp_done, exp_busy);
      end else pass_cnt++;
      if (exp_done) begin
        p = k - (N4 + 1);
        model(va[p], vb[p], vs[p], 16, er, ec, eo);
        total_cnt++;
        if ({sum, cout, ovf} !== {er[15:0], ec, eo}) begin
          $display("FAIL b2b_result%0d: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                   k, sum, cout, ovf, er[15:0], ec, eo);
        end else pass_cnt++;
      end
      va[k] = 16'($urandom); vb[k] = 16'($urandom); vs[k] = 1'($urandom);
      a = va[k]; b = vb[k]; sub = vs[k];
      start = (k < 15);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    int lat, bcyc;
    logic [15:0] rs;
    logic rc, ro;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, sum, cout, ovf} !== 19'd0) begin
      $display("FAIL async_reset: got %h expected 0", {busy, done, sum, cout, ovf});
    end else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, done, sum} !== 18'd0) begin
      $display("FAIL after_reset_idle: got %h expected 0", {busy, done, sum});
    end else pass_cnt++;
    do_op(16'h0001, 16'h0001, 1'b0, lat, bcyc, rs, rc, ro);
    total_cnt++;
    if ({rs, rc, ro} !== {16'h0002, 1'b0, 1'b0} || lat !== N4 + 1) begin
      $display("FAIL post_reset_op: got sum=%h c=%b o=%b lat=%0d expected 0002 0 0 lat=%0d",
               rs, rc, ro, lat, N4 + 1);
    end else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_one_nibble();
    int lat;
    logic [3:0] rs;
    logic rc, ro;
    int unsigned er;
    bit ec, eo;
    do_op1(4'hF, 4'h1, 1'b0, lat, rs, rc, ro);
    total_cnt++;
    if (lat !== 2 || rs !== 4'h0 || rc !== 1'b1) begin
      $display("FAIL nib1_first: got lat=%0d sum=%h c=%b expected lat=2 sum=0 c=1",
               lat, rs, rc);
    end else pass_cnt++;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          model(x, y, s[0], 4, er, ec, eo);
          do_op1(4'(x), 4'(y), s[0], lat, rs, rc, ro);
          total_cnt++;
          if (lat !== 2 || {rs, rc, ro} !== {er[3:0], ec, eo}) begin
            $display("FAIL nib1_%0d_%h_%h: got sum=%h c=%b o=%b lat=%0d expected %h %b %b",
                     s, x, y, rs, rc, ro, lat, er[3:0], ec, eo);
          end else pass_cnt++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_one_nibble();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
